// File: rtl/prbs_symbol_checker_pkg.sv
// Shared constants and types for the PRBS-7 symbol checker. The compliance-pattern
// generator must use these same tap and width constants.
package prbs_symbol_checker_pkg;

  localparam int PRBS7_TAP_A  = 7;
  localparam int PRBS7_TAP_B  = 6;
  localparam int SYMBOL_WIDTH = 10;
  localparam int HIST_WIDTH   = PRBS7_TAP_A;

  typedef enum logic [1:0] {
    ST_SEEK      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_e;

  typedef logic [SYMBOL_WIDTH-1:0] symbol_t;
  typedef logic [HIST_WIDTH-1:0]   hist_t;

  // The newest seven bits of a symbol are all the recurrence needs to continue it.
  function automatic hist_t hist_of(input symbol_t s);
    return s[SYMBOL_WIDTH-1 -: HIST_WIDTH];
  endfunction

endpackage

// File: rtl/prbs7_step10.sv
// Combinational PRBS-7 predictor: extends a 7-bit history (bit 0 oldest) by one
// 10-bit symbol, reusing bits predicted earlier in the same symbol.
module prbs7_step10
  import prbs_symbol_checker_pkg::*;
(
  input  hist_t   hist_i,
  output symbol_t pred_o,
  output hist_t   next_hist_o
);

  logic [HIST_WIDTH+SYMBOL_WIDTH-1:0] ext;

  always_comb begin
    ext = '0;
    ext[HIST_WIDTH-1:0] = hist_i;
    for (int i = HIST_WIDTH; i < HIST_WIDTH + SYMBOL_WIDTH; i++) begin
      ext[i] = ext[i-PRBS7_TAP_A] ^ ext[i-PRBS7_TAP_B];
    end
  end

  assign pred_o      = ext[HIST_WIDTH+SYMBOL_WIDTH-1:HIST_WIDTH];
  assign next_hist_o = hist_of(pred_o);

endmodule

// File: rtl/prbs_symbol_checker.sv
// PRBS-7 receive checker: slips the deserializer until received symbols follow the
// sequence, then free-runs its own prediction and counts bit/symbol errors.
module prbs_symbol_checker
  import prbs_symbol_checker_pkg::*;
#(
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 4,
  parameter int SLIP_WAIT    = 8,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    symbol_valid_i,
  input  logic [SYMBOL_WIDTH-1:0] symbol_i,
  input  logic                    clear_counts_i,
  output logic                    bitslip_o,
  output logic                    locked_o,
  output logic                    error_o,
  output logic [COUNT_WIDTH-1:0]  bit_error_count_o,
  output logic [COUNT_WIDTH-1:0]  symbol_error_count_o
);

  localparam int MATCH_W = $clog2(LOCK_COUNT);
  localparam int RUN_W   = $clog2(UNLOCK_COUNT + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int POP_W   = $clog2(SYMBOL_WIDTH + 1);

  state_e                 state_q, state_d;
  logic                   primed_q, primed_d;
  logic [MATCH_W-1:0]     match_cnt_q, match_cnt_d;
  logic [RUN_W-1:0]       err_run_q, err_run_d;
  logic [WAIT_W-1:0]      slip_cnt_q, slip_cnt_d;
  hist_t                  rx_hist_q, rx_hist_d;
  hist_t                  lk_hist_q, lk_hist_d;
  logic                   bitslip_q, bitslip_d;
  logic                   locked_q, locked_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [COUNT_WIDTH-1:0] sym_cnt_q, sym_cnt_d;

  symbol_t            seek_pred, lock_pred;
  hist_t              seek_next, lock_next;
  symbol_t            lock_diff;
  logic [POP_W-1:0]   diff_pop;
  logic               seek_match, seek_cmp, seek_fail, seek_lock;
  logic               lk_valid, lk_errored, lk_drop, wait_done;

  // One predictor follows the received stream, the other our own free-running copy.
  prbs7_step10 u_seek_step (
    .hist_i      (rx_hist_q),
    .pred_o      (seek_pred),
    .next_hist_o (seek_next)
  );

  prbs7_step10 u_lock_step (
    .hist_i      (lk_hist_q),
    .pred_o      (lock_pred),
    .next_hist_o (lock_next)
  );

  function automatic logic [COUNT_WIDTH-1:0] sat_add(
    input logic [COUNT_WIDTH-1:0] base,
    input logic [POP_W-1:0]       inc
  );
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, base} + (COUNT_WIDTH+1)'(inc);
    return sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
  endfunction

  always_comb begin
    diff_pop = '0;
    for (int i = 0; i < SYMBOL_WIDTH; i++) begin
      diff_pop = diff_pop + POP_W'(lock_diff[i]);
    end
  end

  // An all-zero symbol would seed the lockup state, so it never counts as a match.
  assign seek_match = (symbol_i == seek_pred) && (symbol_i != '0);
  assign lock_diff  = symbol_i ^ lock_pred;
  assign seek_cmp   = (state_q == ST_SEEK) && symbol_valid_i && primed_q;
  assign seek_fail  = seek_cmp && !seek_match;
  assign seek_lock  = seek_cmp && seek_match && (match_cnt_q == MATCH_W'(LOCK_COUNT - 1));
  assign lk_valid   = (state_q == ST_LOCKED) && symbol_valid_i;
  assign lk_errored = lk_valid && (lock_diff != '0);
  assign lk_drop    = lk_errored && (err_run_q == RUN_W'(UNLOCK_COUNT - 1));
  assign wait_done  = (state_q == ST_SLIP_WAIT) && (slip_cnt_q == WAIT_W'(SLIP_WAIT - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_SEEK;
      primed_q    <= 1'b0;
      match_cnt_q <= '0;
      err_run_q   <= '0;
      slip_cnt_q  <= '0;
      rx_hist_q   <= '0;
      lk_hist_q   <= '0;
      bitslip_q   <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      bit_cnt_q   <= '0;
      sym_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      primed_q    <= primed_d;
      match_cnt_q <= match_cnt_d;
      err_run_q   <= err_run_d;
      slip_cnt_q  <= slip_cnt_d;
      rx_hist_q   <= rx_hist_d;
      lk_hist_q   <= lk_hist_d;
      bitslip_q   <= bitslip_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      bit_cnt_q   <= bit_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SEEK: begin
        if (seek_fail) begin
          state_d = ST_SLIP_WAIT;
        end else if (seek_lock) begin
          state_d = ST_LOCKED;
        end
      end
      ST_SLIP_WAIT: begin
        if (wait_done) begin
          state_d = ST_SEEK;
        end
      end
      ST_LOCKED: begin
        if (lk_drop) begin
          state_d = ST_SEEK;
        end
      end
      default: state_d = ST_SEEK;
    endcase
  end

  always_comb begin
    primed_d    = primed_q;
    match_cnt_d = match_cnt_q;
    err_run_d   = err_run_q;
    slip_cnt_d  = slip_cnt_q;
    rx_hist_d   = rx_hist_q;
    lk_hist_d   = lk_hist_q;
    unique case (state_q)
      ST_SEEK: begin
        if (symbol_valid_i) begin
          if (!primed_q) begin
            rx_hist_d = hist_of(symbol_i);
            primed_d  = 1'b1;
          end else if (seek_match) begin
            rx_hist_d   = seek_next;
            match_cnt_d = match_cnt_q + 1'b1;
            if (seek_lock) begin
              lk_hist_d   = hist_of(symbol_i);
              match_cnt_d = '0;
              err_run_d   = '0;
              primed_d    = 1'b0;
            end
          end else begin
            match_cnt_d = '0;
            primed_d    = 1'b0;
            slip_cnt_d  = '0;
          end
        end
      end
      ST_SLIP_WAIT: begin
        slip_cnt_d = wait_done ? '0 : slip_cnt_q + 1'b1;
      end
      ST_LOCKED: begin
        if (lk_valid) begin
          lk_hist_d = lock_next;
          if (lk_errored) begin
            err_run_d = err_run_q + 1'b1;
            if (lk_drop) begin
              err_run_d   = '0;
              primed_d    = 1'b0;
              match_cnt_d = '0;
            end
          end else begin
            err_run_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs; a clear in the same cycle as an error loads just that increment.
  always_comb begin
    bitslip_d = seek_fail;
    error_d   = lk_errored;
    locked_d  = (state_d == ST_LOCKED);
    bit_cnt_d = sat_add(clear_counts_i ? '0 : bit_cnt_q, lk_errored ? diff_pop : '0);
    sym_cnt_d = sat_add(clear_counts_i ? '0 : sym_cnt_q, POP_W'(lk_errored));
  end

  assign bitslip_o            = bitslip_q;
  assign locked_o             = locked_q;
  assign error_o              = error_q;
  assign bit_error_count_o    = bit_cnt_q;
  assign symbol_error_count_o = sym_cnt_q;

endmodule

// File: tb/tb_prbs_symbol_checker.sv
// Randomized bench for prbs_symbol_checker: a bit-level PRBS-7 source, a rotating
// deserializer that honours bitslip, and a behavioural checker model compared every cycle.
module tb_prbs_symbol_checker;

  localparam int LOCK_COUNT   = 64;
  localparam int UNLOCK_COUNT = 4;
  localparam int SLIP_WAIT    = 8;
  localparam int CW           = 4;
  localparam int SAT          = (1 << CW) - 1;
  localparam int M_SEEK = 0, M_WAIT = 1, M_LOCKED = 2;

  logic          clk = 1'b0, rst_n = 1'b0, valid = 1'b0, clr = 1'b0;
  logic [9:0]    sym = '0;
  logic          bitslip, locked, err;
  logic [CW-1:0] bcnt, scnt;

  prbs_symbol_checker #(
    .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT),
    .SLIP_WAIT(SLIP_WAIT), .COUNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .symbol_valid_i(valid), .symbol_i(sym),
    .clear_counts_i(clr), .bitslip_o(bitslip), .locked_o(locked), .error_o(err),
    .bit_error_count_o(bcnt), .symbol_error_count_o(scnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One full period of the sequence, seeded with seven ones.
  bit prbs [127];
  int k   = 0;    // index of the next aligned word on the wire
  int rot = 0;    // word rotation the deserializer currently applies
  bit release_pending = 1'b1;

  function automatic logic [9:0] word(input int idx);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[i] = prbs[(10 * idx + i) % 127];
    return w;
  endfunction

  function automatic logic [9:0] predict(input logic [9:0] w);
    bit b [17];
    logic [9:0] p;
    for (int i = 0; i < 7; i++) b[i] = w[i + 3];
    for (int n = 7; n < 17; n++) b[n] = b[n - 7] ^ b[n - 6];
    for (int i = 0; i < 10; i++) p[i] = b[i + 7];
    return p;
  endfunction

  function automatic logic [9:0] rotw(input logic [9:0] a, input int r);
    logic [19:0] x;
    x = {a, a} >> r;
    return x[9:0];
  endfunction

  function automatic int sat(input int x);
    return (x > SAT) ? SAT : x;
  endfunction

  // Checker model: previous received word in SEEK, expected next word in LOCKED.
  int         m_mode, m_prev, m_run, m_wait;
  logic [9:0] m_expect;
  bit         exp_locked, exp_slip, exp_err;
  int         exp_bcnt, exp_scnt;

  task automatic model_reset();
    m_mode = M_SEEK; m_prev = -1; m_run = 0; m_wait = 0; m_expect = '0;
    exp_locked = 0; exp_slip = 0; exp_err = 0; exp_bcnt = 0; exp_scnt = 0;
  endtask

  task automatic model_step(input bit v, input logic [9:0] s, input bit c);
    int inc_b, inc_s;
    logic [9:0] d;
    inc_b = 0; inc_s = 0;
    exp_slip = 0; exp_err = 0;
    case (m_mode)
      M_WAIT: begin
        m_wait++;
        if (m_wait == SLIP_WAIT) m_mode = M_SEEK;
      end
      M_SEEK: if (v) begin
        if (m_prev < 0) begin
          m_prev = int'(s);
        end else if (s != 0 && s == predict(10'(m_prev))) begin
          m_prev = int'(s);
          m_run++;
          if (m_run == LOCK_COUNT) begin
            m_mode = M_LOCKED; m_run = 0; m_expect = predict(s);
          end
        end else begin
          m_prev = -1; m_run = 0; m_wait = 0; m_mode = M_WAIT; exp_slip = 1;
        end
      end
      M_LOCKED: if (v) begin
        d = s ^ m_expect;
        m_expect = predict(m_expect);
        if (d != 0) begin
          exp_err = 1; inc_s = 1; inc_b = $countones(d); m_run++;
          if (m_run == UNLOCK_COUNT) begin
            m_mode = M_SEEK; m_prev = -1; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      default: ;
    endcase
    exp_locked = (m_mode == M_LOCKED);
    exp_bcnt = sat((c ? 0 : exp_bcnt) + inc_b);
    exp_scnt = sat((c ? 0 : exp_scnt) + inc_s);
  endtask

  // One clock cycle: drive at negedge, model the posedge, leave time at posedge+1.
  task automatic send(input bit v, input logic [9:0] mask, input bit c);
    @(negedge clk);
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 1'b0;
    end
    valid = v;
    clr   = c;
    sym   = v ? (rotw(word(k), rot) ^ mask) : 10'($urandom);
    if (v) k++;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else        model_step(v, sym, c);
    if (exp_slip) rot = (rot == 0) ? 9 : rot - 1;
  endtask

  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_error", err, 0);
    chk("rst_bitcnt", bcnt, 0);
    chk("rst_symcnt", scnt, 0);
  endtask

  always @(negedge clk) begin
    chk("cyc_locked", locked, exp_locked);
    chk("cyc_bitslip", bitslip, exp_slip);
    chk("cyc_error", err, exp_err);
    chk("cyc_bitcnt", bcnt, exp_bcnt);
    chk("cyc_symcnt", scnt, exp_scnt);
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lock_at, slips;
    logic [9:0] m;
    for (int n = 0; n < 127; n++) prbs[n] = (n < 7) ? 1'b1 : (prbs[n - 7] ^ prbs[n - 6]);
    model_reset();
    #3;
    chk("reset_locked", locked, 0);
    chk("reset_bitslip", bitslip, 0);
    chk("reset_bitcnt", bcnt, 0);
    chk("pin_word0", word(0), 10'h07F);
    chk("pin_word1", word(1), 10'h208);
    chk("pin_predict", predict(10'h07F), 10'h208);

    // Clean aligned stream: prime plus 64 matches.
    lock_at = 0; slips = 0;
    for (int i = 1; i <= 80; i++) begin
      send(1, '0, 0);
      if (bitslip) slips++;
      if (locked && lock_at == 0) lock_at = i;
    end
    chk("clean_lock_symbol", lock_at, 65);
    chk("clean_slips", slips, 0);
    chk("clean_symcnt", scnt, 0);

    // Single symbol with bits 0 and 5 flipped.
    send(1, 10'h021, 0);
    chk("flip_error", err, 1);
    chk("flip_symcnt", scnt, 1);
    chk("flip_bitcnt", bcnt, 2);
    chk("flip_locked", locked, 1);
    send(1, '0, 0);
    chk("flip_after_error", err, 0);

    // Four consecutive corrupted symbols drop lock.
    for (int i = 0; i < 4; i++) begin
      send(1, 10'($urandom_range(1, 1023)), 0);
      if (i == 2) chk("drop_locked_after3", locked, 1);
    end
    chk("drop_locked_after4", locked, 0);
    chk("drop_symcnt", scnt, 5);
    chk("drop_bitcnt_ge6", int'(bcnt >= 6), 1);
    for (int i = 0; i < 10; i++) send(1, '0, 0);
    chk("hold_symcnt", scnt, 5);
    for (int i = 0; i < 400 && !locked; i++) send($urandom_range(0, 3) != 0, '0, 0);
    chk("relock", locked, 1);

    // Saturation: 20 errored symbols, never more than three in a row.
    for (int e = 0; e < 20; ) begin
      for (int j = 0; j < 3 && e < 20; j++, e++) send(1, 10'($urandom_range(1, 1023)), 0);
      send(1, '0, 0);
    end
    chk("sat_symcnt", scnt, SAT);
    chk("sat_bitcnt", bcnt, SAT);
    chk("sat_locked", locked, 1);
    send(1, 10'h300, 0);
    chk("sat_symcnt_stays", scnt, SAT);
    send(1, '0, 0);
    send(1, 10'h007, 1);
    chk("clear_bitcnt", bcnt, 3);
    chk("clear_symcnt", scnt, 1);
    for (int i = 0; i < 5; i++) send(1, '0, $urandom_range(0, 1));

    // Async reset while locked and valid held high.
    chk("pre_reset_locked", locked, 1);
    async_reset();
    send(1, '0, 0);
    send(1, '0, 0);
    release_pending = 1'b1;
    lock_at = 0;
    for (int i = 1; i <= 80; i++) begin
      send(1, '0, 0);
      if (locked && lock_at == 0) lock_at = i;
    end
    chk("reset_relock_symbol", lock_at, 65);

    // Words rotated by three bits: the model slips back into alignment.
    async_reset();
    send(1, '0, 0);
    rot = 3;
    release_pending = 1'b1;
    slips = 0;
    for (int i = 0; i < 600 && !locked; i++) begin
      m = '0;
      send($urandom_range(0, 7) != 0, m, 0);
      if (bitslip) slips++;
    end
    chk("rot_slips", slips, 3);
    chk("rot_locked", locked, 1);
    chk("rot_aligned", rot, 0);
    for (int i = 0; i < 20; i++) send(1, '0, 0);
    chk("rot_clean_symcnt", scnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
